fb_writer: RTL and testbench
============================

# fb_writer

Framebuffer write stage that sits directly downstream of `rtx`. It takes each finished pixel (`pixel_color`, `pixel_h`, `pixel_v`, `ray_done`) and converts the fp24 colour to RGB888 with clamping. It computes the linear framebuffer address and buffers the result in a small FIFO, then drives a valid/ready write port into the framebuffer BRAM arbiter. It also tracks frame completion.

## Interface

Parameters:
- `WIDTH`, default 1280: pixels per line.
- `HEIGHT`, default 720: lines per frame.
- `DEPTH`, default 4: FIFO entries; must be a power of two, ≥2.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `pixel_color`, in, 72 (`fp24_vec3`): `{r,g,b}` = `[71:48]`, `[47:24]`, `[23:0]`.
- `pixel_h`, in, 11: column.
- `pixel_v`, in, 10: row.
- `pixel_valid`, in, 1: one-cycle pulse per pixel; connected to `rtx.ray_done`. There is no backpressure towards `rtx`.
- `fb_addr`, out, `$clog2(WIDTH*HEIGHT)`: linear address, `v*WIDTH + h`.
- `fb_data`, out, 24: `{R8,G8,B8}`.
- `fb_valid`, out, 1: write request.
- `fb_ready`, in, 1: framebuffer accepts the write in this cycle.
- `frame_done`, out, 1: one-cycle pulse.
- `frame_count`, out, 16: completed frames; wraps from 0xFFFF to 0.
- `overflow`, out, 1: sticky pixel-drop flag.

## Operation

- **fp24 format:** sign[23], exponent[22:16] with bias 63, mantissa[15:0].
- **Per-channel conversion** to u8:
  - sign=1 → 0.
  - exponent==0 → 0.
  - exponent ≥ 63 (value ≥ 1.0) → 255.
  - exponent ≤ 54 → 0.
  - Otherwise `({1'b1,mant} >> (71-exp))[7:0]`, i.e. truncation of v·256.
- **Pipeline:**
  - S1 registers the three converted channels, `h` and `v`, and a valid bit.
  - S2 registers `addr = v*WIDTH + h` (constant multiply), data and valid.
  - S2's valid pushes into the FIFO.
- **FIFO:**
  - Holds `{addr,data}`.
  - First-word fall-through: `fb_valid` = not empty, and `fb_addr`/`fb_data` show the head entry.
  - Pop occurs when `fb_valid && fb_ready`.
- **Ordering:** strict arrival order.
- **Full FIFO:**
  - Push while full with no pop in the same cycle → pixel dropped and `overflow` set until `rst`.
  - Push and pop in the same cycle while full → both occur, no drop.
  - Push and pop in the same cycle while empty → normal push; the entry appears the next cycle.
- **Frame tracking:**
  - When an entry with `addr == WIDTH*HEIGHT-1` is popped, `frame_done` pulses in the next cycle and `frame_count` increments in that same cycle.
  - Dropped pixels never trigger `frame_done`.
- **Robustness:** out-of-range `h`/`v` are not checked; the address is passed through, truncated to the port width.

## Timing

- **Reset values:** `fb_valid`=0, `fb_addr`=0, `fb_data`=0, `frame_done`=0, `frame_count`=0, `overflow`=0. Pipeline valids cleared; FIFO emptied.
- **Latency:** `pixel_valid` in cycle N → S1 valid in N+1 → S2 valid in N+2 → FIFO entry visible and `fb_valid`=1 in N+3 (FIFO empty).
- **Throughput:** one pixel per cycle when `fb_ready` is held high.
- **Stall rule:** `fb_addr`/`fb_data` stay stable while `fb_valid && !fb_ready`.
- **Reset mid-operation:** `rst` in cycle N discards all in-flight pixels. Outputs are at reset values from N+1. A `pixel_valid` coinciding with `rst` is ignored.

## Structure

- **Shared package:**
  - Existing `fp24` / `fp24_vec3` typedefs.
  - New `rgb888` packed struct `{r,g,b}`.
  - Constants `FP24_EXP_BIAS = 63`, `FP24_MANT_W = 16`.
- **Sub-module `fp24_to_u8`:** combinational converter, instantiated three times.
- **FIFO:** inline in `fb_writer` as a register array plus read/write pointers and a count, sized by `DEPTH`.

## Test plan

1. **Basic conversion.** Colour (0x3f0000, 0x3e0000, 0x000000) at (0,0), `fb_ready`=1 → `fb_valid` in cycle N+3 with `fb_addr`=0 and `fb_data`=0xFF8000.
2. **Clamp and edge cases.** r=0xbf0000 (−1.0), g=0x370000 (2⁻⁸), b=0x7f0000 (huge) at (5,2) → `fb_data`=0x0001FF and `fb_addr`=2565.
3. **End of frame.** Pixel (1279,719) → `fb_addr`=921599. `frame_done` pulses one cycle after the pop and `frame_count` goes 0→1. A second such pixel → `frame_count`=2.
4. **Backpressure and overflow.** `fb_ready`=0; inject 5 pixels on consecutive cycles with `DEPTH`=4.
   - 4 pixels are held and `overflow`=1.
   - Raise `fb_ready` → exactly 4 writes, in order, with the 5th dropped.
   - `overflow` stays 1.
5. **Full-FIFO push and pop.**
   - FIFO full, `fb_ready`=1, and a push arrives in the same cycle → no drop and `overflow` stays 0.
   - Count stays at 4.
6. **Reset mid-stream.**
   - Assert `rst` with 3 pixels in flight → all outputs 0 in the next cycle.
   - No stale write appears afterwards.
   - A new pixel then completes normally with 3-cycle latency.

Source files
------------

// File: rtl/fb_writer_pkg.sv
// Shared types and constants for the ray-tracer output path.
package fb_writer_pkg;

    // fp24 layout: sign[23], exponent[22:16] (biased), mantissa[15:0]
    localparam int unsigned FP24_EXP_BIAS = 63;
    localparam int unsigned FP24_MANT_W   = 16;

    typedef logic [23:0] fp24;

    typedef struct packed {
        fp24 r;
        fp24 g;
        fp24 b;
    } fp24_vec3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888;

endpackage

// File: rtl/fb_writer_fp24_to_u8.sv
// Combinational fp24 -> u8 colour channel conversion with clamping to [0, 255].
module fp24_to_u8
    import fb_writer_pkg::*;
(
    input  fp24        val,
    output logic [7:0] u8
);

    logic                 sign;
    logic [6:0]           expo;
    logic [FP24_MANT_W:0] sig;
    logic [6:0]           shamt;

    assign sign = val[23];
    assign expo = val[22:16];
    assign sig  = {1'b1, val[FP24_MANT_W-1:0]};

    // Result is v*256 truncated: shifting the 1.m significand right by (bias+8-exp).
    always_comb begin
        shamt = 7'(FP24_EXP_BIAS + 8) - expo;
        if (sign || expo == '0) begin
            u8 = '0;
        end else if (expo >= 7'(FP24_EXP_BIAS)) begin
            u8 = 8'hff;
        end else if (expo <= 7'(FP24_EXP_BIAS - 9)) begin
            u8 = '0;
        end else begin
            u8 = 8'(sig >> shamt);
        end
    end

endmodule

// File: rtl/fb_writer.sv
// Framebuffer write stage: fp24 colour -> RGB888, linear address, FWFT FIFO,
// valid/ready write port and frame completion tracking.
module fb_writer
    import fb_writer_pkg::*;
#(
    parameter int unsigned WIDTH  = 1280,
    parameter int unsigned HEIGHT = 720,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  fp24_vec3                         pixel_color,
    input  logic [10:0]                      pixel_h,
    input  logic [9:0]                       pixel_v,
    input  logic                             pixel_valid,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]  fb_addr,
    output logic [23:0]                      fb_data,
    output logic                             fb_valid,
    input  logic                             fb_ready,
    output logic                             frame_done,
    output logic [15:0]                      frame_count,
    output logic                             overflow
);

    localparam int unsigned   AW        = $clog2(WIDTH * HEIGHT);
    localparam int unsigned   PW        = $clog2(DEPTH);
    localparam int unsigned   CW        = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH * HEIGHT - 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        rgb888         data;
    } fifo_entry_t;

    // ---------------------------------------------------------------- conversion
    rgb888 conv;

    fp24_to_u8 u_conv_r (.val(pixel_color.r), .u8(conv.r));
    fp24_to_u8 u_conv_g (.val(pixel_color.g), .u8(conv.g));
    fp24_to_u8 u_conv_b (.val(pixel_color.b), .u8(conv.b));

    // ---------------------------------------------------------------- stage 1
    logic        s1_valid;
    rgb888       s1_data;
    logic [10:0] s1_h;
    logic [9:0]  s1_v;

    // S1 valid; a pixel arriving together with reset is discarded.
    always_ff @(posedge clk) begin
        if (rst) s1_valid <= 1'b0;
        else     s1_valid <= pixel_valid;
    end

    // S1 payload; only meaningful when s1_valid is set.
    always_ff @(posedge clk) begin
        s1_data <= conv;
        s1_h    <= pixel_h;
        s1_v    <= pixel_v;
    end

    // ---------------------------------------------------------------- stage 2
    logic [AW-1:0] s1_addr;
    logic          s2_valid;
    logic [AW-1:0] s2_addr;
    rgb888         s2_data;

    // Out-of-range coordinates are not checked; the sum just wraps to AW bits.
    assign s1_addr = AW'(s1_v) * AW'(WIDTH) + AW'(s1_h);

    // S2 valid.
    always_ff @(posedge clk) begin
        if (rst) s2_valid <= 1'b0;
        else     s2_valid <= s1_valid;
    end

    // S2 payload.
    always_ff @(posedge clk) begin
        s2_addr <= s1_addr;
        s2_data <= s1_data;
    end

    // ---------------------------------------------------------------- FIFO
    fifo_entry_t   mem [DEPTH];
    fifo_entry_t   head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          push;
    logic          pop;
    logic          do_push;

    assign full     = (count == CW'(DEPTH));
    assign fb_valid = (count != '0);
    assign pop      = fb_valid && fb_ready;
    assign push     = s2_valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push  = push && (!full || pop);
    assign head     = mem[rd_ptr];

    // Head is gated so the port reads zero while empty (and after reset).
    assign fb_addr = fb_valid ? head.addr : '0;
    assign fb_data = fb_valid ? head.data : '0;

    // Storage array; no reset needed, occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= '{addr: s2_addr, data: s2_data};
    end

    // Read/write pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky drop flag: a push into a full FIFO with no simultaneous pop.
    always_ff @(posedge clk) begin
        if (rst)                       overflow <= 1'b0;
        else if (push && full && !pop) overflow <= 1'b1;
    end

    // ---------------------------------------------------------------- frame tracking
    logic last_pop;

    assign last_pop = pop && (head.addr == LAST_ADDR);

    // Frame completes when the last pixel of the frame is written out.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= last_pop;
            if (last_pop) frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer: table vectors, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_fb_writer;
    import fb_writer_pkg::*;

    localparam int unsigned WIDTH  = 1280;
    localparam int unsigned HEIGHT = 720;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned AW     = $clog2(WIDTH * HEIGHT);
    localparam logic [AW-1:0] LAST = AW'(WIDTH * HEIGHT - 1);

    logic          clk = 1'b0;
    logic          rst;
    fp24_vec3      pixel_color;
    logic [10:0]   pixel_h;
    logic [9:0]    pixel_v;
    logic          pixel_valid;
    logic [AW-1:0] fb_addr;
    logic [23:0]   fb_data;
    logic          fb_valid;
    logic          fb_ready;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic          overflow;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fb_writer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_color (pixel_color),
        .pixel_h     (pixel_h),
        .pixel_v     (pixel_v),
        .pixel_valid (pixel_valid),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .fb_valid    (fb_valid),
        .fb_ready    (fb_ready),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .overflow    (overflow)
    );

    // ------------------------------------------------------------ reference model
    typedef struct {
        logic [AW-1:0] addr;
        logic [23:0]   data;
    } ent_t;

    ent_t        fifo_m[$];
    bit          pend_v[2];
    ent_t        pend_e[2];
    bit          ovf_m = 1'b0;
    bit          fd_m  = 1'b0;
    logic [15:0] fc_m  = '0;

    // Real-valued conversion: floor(value * 256), clamped to 255.
    function automatic logic [7:0] conv_m(logic [23:0] f);
        int  e;
        real val;
        e = int'(f[22:16]);
        if (f[23] || e == 0) return 8'd0;
        val = (1.0 + real'(f[15:0]) / 65536.0) * $pow(2.0, real'(e - 63)) * 256.0;
        val = $floor(val);
        if (val >= 255.0) return 8'd255;
        return 8'($rtoi(val));
    endfunction

    function automatic ent_t mk_ent(logic [71:0] c, logic [10:0] h, logic [9:0] v);
        ent_t        e;
        int unsigned a;
        a      = 32'(v) * WIDTH + 32'(h);
        e.addr = AW'(a);
        e.data = {conv_m(c[71:48]), conv_m(c[47:24]), conv_m(c[23:0])};
        return e;
    endfunction

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        ent_t e;
        if (rst) begin
            fifo_m.delete();
            pend_v = '{1'b0, 1'b0};
            ovf_m  = 1'b0;
            fd_m   = 1'b0;
            fc_m   = '0;
            return;
        end
        fd_m = 1'b0;
        if (fifo_m.size() != 0 && fb_ready) begin
            e = fifo_m.pop_front();
            if (e.addr == LAST) begin
                fd_m = 1'b1;
                fc_m = fc_m + 16'd1;
            end
        end
        // A pixel reaches the FIFO two edges after it is sampled.
        if (pend_v[1]) begin
            if (fifo_m.size() < int'(DEPTH)) fifo_m.push_back(pend_e[1]);
            else                             ovf_m = 1'b1;
        end
        pend_v[1] = pend_v[0];
        pend_e[1] = pend_e[0];
        pend_v[0] = pixel_valid;
        pend_e[0] = mk_ent(pixel_color, pixel_h, pixel_v);
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        check("m_fb_valid", 32'(fb_valid), 32'(fifo_m.size() != 0));
        if (fifo_m.size() != 0) begin
            check("m_fb_addr", 32'(fb_addr), 32'(fifo_m[0].addr));
            check("m_fb_data", 32'(fb_data), 32'(fifo_m[0].data));
        end
        check("m_frame_done", 32'(frame_done), 32'(fd_m));
        check("m_frame_count", 32'(frame_count), 32'(fc_m));
        check("m_overflow", 32'(overflow), 32'(ovf_m));
    endtask

    // One clock: model and DUT both cross the edge, then compare at the negedge.
    task automatic tick();
        model_step();
        @(negedge clk);
        model_check();
    endtask

    task automatic drive(logic [71:0] c, int h, int v);
        pixel_color = c;
        pixel_h     = 11'(h);
        pixel_v     = 10'(v);
        pixel_valid = 1'b1;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_fb_valid"}, 32'(fb_valid), 32'd0);
        check({tag, "_fb_addr"}, 32'(fb_addr), 32'd0);
        check({tag, "_fb_data"}, 32'(fb_data), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    // Single pixel through an empty pipe with fb_ready high: visible in N+3.
    task automatic run_latency(string tag, logic [71:0] c, int h, int v,
                               logic [AW-1:0] addr, logic [23:0] data);
        drive(c, h, v);
        tick();
        pixel_valid = 1'b0;
        check({tag, "_lat1"}, 32'(fb_valid), 32'd0);
        tick();
        check({tag, "_lat2"}, 32'(fb_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(fb_valid), 32'd1);
        check({tag, "_addr"}, 32'(fb_addr), 32'(addr));
        check({tag, "_data"}, 32'(fb_data), 32'(data));
        tick();
    endtask

    function automatic logic [23:0] rand_fp24();
        logic [6:0] e;
        e = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                        : 7'($urandom_range(53, 64));
        return {1'($urandom_range(0, 7) == 0), e, 16'($urandom)};
    endfunction

    typedef struct {
        logic [71:0]   color;
        int            h;
        int            v;
        logic [AW-1:0] addr;
        logic [23:0]   data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_pop;
        int ready_pct;

        vecs[0] = '{72'h3f0000_3e0000_000000, 0, 0, AW'(0), 24'hFF8000};
        vecs[1] = '{72'hbf0000_370000_7f0000, 5, 2, AW'(2565), 24'h0001FF};
        vecs[2] = '{72'h3e8000_380000_360000, 100, 3, AW'(3940), 24'hC00200};
        vecs[3] = '{72'h3dffff_000001_800000, 1279, 0, AW'(1279), 24'h7F0000};
        vecs[4] = '{72'h3effff_3f0001_400000, 0, 719, AW'(920320), 24'hFFFFFF};
        vecs[5] = '{72'h390000_3a4000_3b2000, 2047, 1023, AW'(262911), 24'h040A12};

        rst         = 1'b1;
        pixel_valid = 1'b0;
        pixel_color = '0;
        pixel_h     = '0;
        pixel_v     = '0;
        fb_ready    = 1'b0;
        @(negedge clk);
        tick();
        tick();
        check_reset_outputs("reset");
        rst      = 1'b0;
        fb_ready = 1'b1;
        tick();

        // Conversion and address table, including clamps and wrapped addresses.
        for (int i = 0; i < 6; i++) begin
            run_latency($sformatf("vec%0d", i), vecs[i].color, vecs[i].h, vecs[i].v,
                        vecs[i].addr, vecs[i].data);
        end

        // End of frame, twice.
        for (int k = 1; k <= 2; k++) begin
            run_latency("eof", 72'h3f0000_3f0000_3f0000, 1279, 719, LAST, 24'hFFFFFF);
            check("eof_done", 32'(frame_done), 32'd1);
            check("eof_count", 32'(frame_count), 32'(k));
            tick();
            check("eof_done_clr", 32'(frame_done), 32'd0);
        end

        // Backpressure: five pixels into a four-entry FIFO, fifth dropped.
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(72'h3e0000_3e0000_3e0000, 10 + i, 1);
            tick();
        end
        pixel_valid = 1'b0;
        tick();
        tick();
        tick();
        check("bp_overflow", 32'(overflow), 32'd1);
        fb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", 32'(fb_valid), 32'd1);
            check("bp_order", 32'(fb_addr), 32'(1290 + i));
            tick();
        end
        check("bp_drained", 32'(fb_valid), 32'd0);
        check("bp_overflow_sticky", 32'(overflow), 32'd1);

        // Full FIFO with simultaneous push and pop: nothing lost.
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(72'h3d0000_3c0000_3b0000, 20 + i, 2);
            tick();
        end
        pixel_valid = 1'b0;
        tick();
        check("full_overflow_pre", 32'(overflow), 32'd0);
        fb_ready = 1'b1;
        n_pop    = 0;
        for (int c = 0; c < 8; c++) begin
            if (fb_valid) begin
                check("full_order", 32'(fb_addr), 32'(2580 + n_pop));
                n_pop++;
            end
            tick();
        end
        check("full_writes", 32'(n_pop), 32'd5);
        check("full_overflow", 32'(overflow), 32'd0);

        // Reset with three pixels in flight, plus one coinciding with reset.
        for (int i = 0; i < 3; i++) begin
            drive(72'h3f0000_000000_3f0000, 30 + i, 3);
            tick();
        end
        drive(72'h3f0000_3f0000_3f0000, 40, 3);
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        pixel_valid = 1'b0;
        check_reset_outputs("midrst");
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_no_stale", 32'(fb_valid), 32'd0);
        end
        run_latency("postrst", 72'h3e0000_3f0000_000000, 50, 3, AW'(3890), 24'h80FF00);

        // Randomized traffic against the model.
        ready_pct = 100;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       ready_pct = 100;
                    1:       ready_pct = 70;
                    default: ready_pct = 30;
                endcase
            end
            rst         = ($urandom_range(0, 399) == 0);
            fb_ready    = ($urandom_range(0, 99) < ready_pct);
            pixel_valid = $urandom_range(0, 1) == 1;
            pixel_color = {rand_fp24(), rand_fp24(), rand_fp24()};
            case ($urandom_range(0, 31))
                0: begin
                    pixel_h = 11'($urandom);
                    pixel_v = 10'($urandom);
                end
                1, 2, 3: begin
                    pixel_h = 11'd1279;
                    pixel_v = 10'd719;
                end
                default: begin
                    pixel_h = 11'($urandom_range(0, 1279));
                    pixel_v = 10'($urandom_range(0, 719));
                end
            endcase
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
